// File: rtl/lu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lu_arbiter
// Brief    : Round-robin arbiter/sequencer sharing one LU_decomposition engine
//            between two requesters. Optional WAIT watchdog: LU_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module lu_arbiter #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req,
    input  logic [511:0] a0_in,
    input  logic [511:0] a1_in,
    output logic [1:0]   ack,
    output logic         busy,
    output logic         owner,
    output logic [511:0] res_l,
    output logic [511:0] res_u,
    output logic         res_err,
    output logic         eng_rst,
    output logic         eng_start,
    output logic [511:0] eng_a,
    input  logic         eng_done,
    input  logic [511:0] eng_l,
    input  logic [511:0] eng_u
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RST_ENG = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_ACK     = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   r_last;
    logic   w_grant;
    logic   w_winner;
    logic   w_timeout;
    logic   w_capture;

`ifdef LU_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_START) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == S_WAIT) && !eng_done &&
                       (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_err <= 1'b0;
        end else if (w_capture) begin
            res_err <= !eng_done;
        end
    end
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^TIMEOUT_CYC;
    assign w_timeout    = 1'b0;
    assign res_err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        // Both requesting: serve whoever was not served last.
        w_winner     = (req == 2'b11) ? ~r_last : req[1];
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_grant      = 1'b1;
                    w_state_next = S_RST_ENG;
                end
            end
            S_RST_ENG: w_state_next = S_START;
            S_START:   w_state_next = S_WAIT;
            S_WAIT: begin
                if (eng_done || w_timeout) begin
                    w_state_next = S_ACK;
                end
            end
            S_ACK:     w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    assign w_capture = (r_state == S_WAIT) && (w_state_next == S_ACK);

    // Outputs are registered from the next state so they are glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last    <= 1'b1;
            owner     <= 1'b0;
            eng_a     <= '0;
            eng_rst   <= 1'b1;
            eng_start <= 1'b0;
            busy      <= 1'b0;
            ack       <= 2'b00;
            res_l     <= '0;
            res_u     <= '0;
        end else begin
            eng_rst   <= (w_state_next == S_RST_ENG) || (w_state_next == S_ACK);
            eng_start <= (w_state_next == S_START);
            busy      <= (w_state_next != S_IDLE);
            ack       <= 2'b00;
            if (w_grant) begin
                owner <= w_winner;
                eng_a <= w_winner ? a1_in : a0_in;
            end
            if (w_capture) begin
                ack <= owner ? 2'b10 : 2'b01;
                if (eng_done) begin
                    res_l <= eng_l;
                    res_u <= eng_u;
                end else begin
                    res_l <= '0;
                    res_u <= '0;
                end
            end
            if (r_state == S_ACK) begin
                r_last <= owner;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lu_arbiter
// Brief    : Self-checking bench for lu_arbiter with a stub LU engine and a
//            job-timeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lu_arbiter;
    localparam int TB_TO = 15;
`ifdef LU_ARB_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req;
    logic [511:0] a0_in, a1_in;
    logic [1:0]   ack;
    logic         busy, owner, res_err, eng_rst, eng_start;
    logic [511:0] res_l, res_u, eng_a;
    logic         eng_done = 1'b0;
    logic [511:0] eng_l = '0, eng_u = '0;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    lu_arbiter #(.TIMEOUT_CYC(TB_TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a0_in(a0_in), .a1_in(a1_in),
        .ack(ack), .busy(busy), .owner(owner), .res_l(res_l), .res_u(res_u),
        .res_err(res_err), .eng_rst(eng_rst), .eng_start(eng_start), .eng_a(eng_a),
        .eng_done(eng_done), .eng_l(eng_l), .eng_u(eng_u)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] setw(input logic [511:0] m, input int r, input int c, input int v);
        m[(r*4+c)*32 +: 32] = v;
        return m;
    endfunction

    // Integer Doolittle LU, same contract as the real engine.
    function automatic void lu4(input logic [511:0] a, output logic [511:0] l, output logic [511:0] u);
        int am[4][4]; int lm[4][4]; int um[4][4]; int s;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                am[i][j] = a[(i*4+j)*32 +: 32];
                lm[i][j] = 0;
                um[i][j] = 0;
            end
        for (int k = 0; k < 4; k++) begin
            for (int j = k; j < 4; j++) begin
                s = am[k][j];
                for (int p = 0; p < k; p++) s = s - lm[k][p] * um[p][j];
                um[k][j] = s;
            end
            lm[k][k] = 1;
            for (int i = k + 1; i < 4; i++) begin
                s = am[i][k];
                for (int p = 0; p < k; p++) s = s - lm[i][p] * um[p][k];
                lm[i][k] = (um[k][k] != 0) ? s / um[k][k] : 0;
            end
        end
        l = '0;
        u = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                l[(i*4+j)*32 +: 32] = lm[i][j];
                u[(i*4+j)*32 +: 32] = um[i][j];
            end
    endfunction

    // Stub engine: done is sticky until eng_rst; outputs are junk until done.
    bit           eng_stall = 1'b0;
    int           eng_lat = 4;
    int           e_cnt = 0;
    logic [511:0] s_l, s_u;
    always @(posedge clk) begin
        if (eng_rst) begin
            eng_done <= 1'b0;
            e_cnt    <= 0;
            eng_l    <= {16{32'hDEADBEEF}};
            eng_u    <= {16{32'hBAADF00D}};
        end else if (eng_start) begin
            e_cnt <= eng_lat;
        end else if (e_cnt > 0) begin
            e_cnt <= e_cnt - 1;
            if (e_cnt == 1 && !eng_stall) begin
                lu4(eng_a, s_l, s_u);
                eng_done <= 1'b1;
                eng_l    <= s_l;
                eng_u    <= s_u;
            end
        end
    end

    // Reference model: a job is a timeline (grant cycle tg, ack cycle ta);
    // every output in cycle n is a simple function of n, tg and ta.
    int           cyc, tg, ta;
    bit           job;
    logic         m_last, m_own, m_busy, m_rst, m_start, m_err;
    logic [1:0]   m_ack;
    logic [511:0] m_mat, m_l, m_u;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; job = 0; tg = -10; ta = -10;
            m_last = 1'b1; m_own = 1'b0; m_mat = '0; m_l = '0; m_u = '0;
            m_err = 1'b0; m_ack = 2'b00; m_busy = 1'b0; m_rst = 1'b1; m_start = 1'b0;
        end else begin
            cyc++;
            if (job && ta == cyc - 1) begin
                job    = 0;
                m_last = m_own;
            end else if (!job) begin
                if (req != 2'b00) begin
                    job   = 1;
                    tg    = cyc;
                    m_own = (req == 2'b11) ? !m_last : req[1];
                    m_mat = m_own ? a1_in : a0_in;
                end
            end else if (ta < tg && cyc - 1 >= tg + 2) begin
                if (eng_done) begin
                    ta = cyc;
                    lu4(m_mat, m_l, m_u);
                    m_err = 1'b0;
                end else if (TO_ON && cyc == tg + 2 + TB_TO) begin
                    ta = cyc;
                    m_l = '0; m_u = '0; m_err = 1'b1;
                end
            end
            m_busy  = job;
            m_rst   = job && (cyc == tg || cyc == ta);
            m_start = job && (cyc == tg + 1);
            m_ack   = (job && cyc == ta) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ack", ack, m_ack);
            chk("busy", busy, m_busy);
            chk("owner", owner, m_own);
            chk("eng_rst", eng_rst, m_rst);
            chk("eng_start", eng_start, m_start);
            chk("eng_a", eng_a, m_mat);
            chk("res_l", res_l, m_l);
            chk("res_u", res_u, m_u);
            chk("res_err", res_err, m_err);
        end
    end

    task automatic wait_ack(input int budget, output logic [1:0] got);
        got = 2'b00;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                got = ack;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_ack: no ack within %0d cycles, got %b required nonzero", budget, ack);
    endtask

    logic [511:0] id_m, num_a, exp_l, exp_u, t_l, t_u;
    logic [1:0]   got;
    int           n;

    initial begin
        id_m = '0;
        for (int i = 0; i < 4; i++) id_m = setw(id_m, i, i, 1);
        num_a = setw(setw(setw(setw(id_m, 0, 0, 2), 0, 1, 1), 1, 0, 4), 1, 1, 3);
        exp_l = setw(id_m, 1, 0, 2);
        exp_u = setw(setw(id_m, 0, 0, 2), 0, 1, 1);

        rst_n = 1'b0; req = 2'b00; a0_in = '0; a1_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_eng_rst", eng_rst, 1'b1);
        chk("rst_eng_start", eng_start, 1'b0);
        chk("rst_owner", owner, 1'b0);
        chk("rst_res_l", res_l, '0);
        chk("rst_res_err", res_err, 1'b0);
        chk("rst_eng_a", eng_a, '0);
        lu4(id_m, t_l, t_u);
        chk("model_id_l", t_l, id_m);
        chk("model_id_u", t_u, id_m);
        lu4(num_a, t_l, t_u);
        chk("model_num_l", t_l, exp_l);
        chk("model_num_u", t_u, exp_u);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // Identity job on requester 0
        a0_in = id_m; req = 2'b01;
        @(negedge clk);
        chk("grant_busy", busy, 1'b1);
        chk("grant_eng_rst", eng_rst, 1'b1);
        chk("grant_no_start", eng_start, 1'b0);
        @(negedge clk);
        chk("start_2nd_cycle", eng_start, 1'b1);
        wait_ack(100, got);
        req = 2'b00;
        chk("id_ack", got, 2'b01);
        chk("id_res_l", res_l, id_m);
        chk("id_res_u", res_u, id_m);
        chk("id_res_err", res_err, 1'b0);
        @(negedge clk);
        chk("id_busy_after", busy, 1'b0);
        chk("id_ack_one_cycle", ack, 2'b00);

        // Numeric job on requester 1, request dropped mid-job
        a1_in = num_a; req = 2'b10; eng_lat = 6;
        @(negedge clk);
        req = 2'b00;
        wait_ack(100, got);
        chk("num_ack", got, 2'b10);
        chk("num_res_l", res_l, exp_l);
        chk("num_res_u", res_u, exp_u);
        chk("num_owner", owner, 1'b1);
        @(negedge clk);

        // Contention from reset release
        #2 rst_n = 1'b0;
        req = 2'b11; a0_in = id_m; a1_in = num_a; eng_lat = 2;
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_ack(100, got);
        chk("cont_ack0", got, 2'b01);
        chk("cont_res0", res_l, id_m);
        wait_ack(100, got);
        chk("cont_ack1", got, 2'b10);
        chk("cont_res1", res_l, exp_l);
        wait_ack(100, got);
        req = 2'b00;
        chk("cont_ack2", got, 2'b01);
        @(negedge clk);

        // Input changed during WAIT must not affect the job
        a0_in = num_a; req = 2'b01; eng_lat = 8;
        repeat (4) @(negedge clk);
        a0_in = id_m;
        wait_ack(100, got);
        req = 2'b00;
        chk("stab_ack", got, 2'b01);
        chk("stab_res_l", res_l, exp_l);
        chk("stab_res_u", res_u, exp_u);
        chk("stab_eng_a", eng_a, num_a);
        @(negedge clk);

        // Asynchronous reset during WAIT
        a0_in = id_m; req = 2'b01; eng_lat = 8;
        n = 0;
        while (!eng_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("mid_started", eng_start, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ack", ack, 2'b00);
        chk("mid_rst_eng_rst", eng_rst, 1'b1);
        chk("mid_rst_start", eng_start, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_ack(100, got);
        req = 2'b00;
        chk("post_rst_ack", got, 2'b01);
        chk("post_rst_res_l", res_l, id_m);
        chk("post_rst_err", res_err, 1'b0);
        @(negedge clk);

`ifdef LU_ARB_TIMEOUT_EN
        // Watchdog: engine never finishes
        eng_stall = 1'b1; a0_in = num_a; req = 2'b01;
        n = 0;
        while (!eng_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0; got = 2'b00;
        while (got == 2'b00 && n < 100) begin
            @(negedge clk);
            n++;
            got = ack;
        end
        req = 2'b00;
        chk("to_latency_15_16", (n >= 15 && n <= 16), 1'b1);
        chk("to_ack", got, 2'b01);
        chk("to_err", res_err, 1'b1);
        chk("to_res_l", res_l, '0);
        chk("to_res_u", res_u, '0);
        @(negedge clk);
        eng_stall = 1'b0; a0_in = num_a; req = 2'b01;
        wait_ack(100, got);
        req = 2'b00;
        chk("after_to_ack", got, 2'b01);
        chk("after_to_err", res_err, 1'b0);
        chk("after_to_res_l", res_l, exp_l);
        @(negedge clk);
`endif

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lu_arbiter.md
# lu_arbiter

Round-robin arbiter and sequencer that shares one `LU_decomposition` engine between two requesters in the matrix-inversion datapath. It grants the engine to one requester per job and forwards that requester's matrix to the engine. It resets the engine before each job, because the engine parks in its done state until reset. It captures the L/U result and returns it with a one-cycle acknowledge.

## Interface
- `TIMEOUT_CYC`, default 1023: cycles allowed in WAIT before a job is aborted (used only with `LU_ARB_TIMEOUT_EN`).
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  2  level request per requester; held until its `ack`.
- `a0_in`, `a1_in`  in  512 each  flattened 4x4 signed 32-bit matrix per requester; word r*4+c at bits [(r*4+c)*32 +: 32].
- `ack`  out  2  one-cycle pulse to the owner; `res_*` valid that cycle.
- `busy`  out  1  high from grant until the ack cycle, inclusive.
- `owner`  out  1  index of the current or last granted requester.
- `res_l`, `res_u`  out  512 each  captured L and U, held until the next capture.
- `res_err`  out  1  high with `ack` when the job timed out.
- `eng_rst`  out  1  active-high synchronous reset to the engine.
- `eng_start`  out  1  engine start pulse.
- `eng_a`  out  512  matrix driven to the engine `A_in`.
- `eng_done`  in  1  engine done; sticky until `eng_rst`.
- `eng_l`, `eng_u`  in  512 each  engine `L_out`/`U_out`; valid when `eng_done`=1.

## Operation
- Reset values: state IDLE.
  - `eng_rst`=1, which holds the engine in reset.
  - `ack`=0, `busy`=0, `eng_start`=0, `owner`=0, `res_err`=0.
  - `res_l`=0, `res_u`=0, `eng_a`=0.
  - Internal last-served pointer = 1, so requester 0 wins the first contention.
- States:
  - IDLE: `eng_rst`=0. If any `req` bit is high:
    - Pick the winner: the only requester, or, if both request, the one not last served.
    - Latch `owner` and `eng_a` from the winner's `aX_in`; set `busy`=1; go to RST_ENG.
  - RST_ENG: `eng_rst`=1 for one cycle; go to START.
  - START: `eng_rst`=0, `eng_start`=1 for one cycle; clear the watchdog counter; go to WAIT.
  - WAIT: `eng_start`=0. When `eng_done`=1:
    - Capture `eng_l`/`eng_u` into `res_l`/`res_u`; set `res_err`=0.
    - Set `ack[owner]`=1; go to ACK.
  - ACK: `ack` high for exactly this cycle.
    - Last-served pointer ← `owner`; `eng_rst`=1 to park the engine.
    - `busy`=0 at exit; go to IDLE.
- `req` is sampled only in IDLE.
  - Dropping `req` mid-job does not abort the job; the ack still pulses.
  - `req` still high in the cycle after ACK is treated as a new job.
- `aX_in` is sampled only at grant; later changes do not affect the running job.
- Results pass through unmodified: no arithmetic in this block.
  - The engine's integer-truncated division and its U[k][k]≠0 requirement are the requester's concern.

## Timing
- Grant edge to `eng_start` high: 2 cycles (RST_ENG, then START).
- `eng_done` sampled high at edge E: `ack`, `res_*` and `res_err` are valid in the cycle after E.
- Job latency = engine latency + 4 cycles of controller overhead.
- Minimum gap between ack and the next grant: 1 cycle (IDLE).
- Asynchronous reset mid-job, in any state:
  - Outputs return to their reset values immediately; no ack is issued.
  - `eng_rst`=1 holds the engine until `rst_n` releases.

## Configuration
- `LU_ARB_TIMEOUT_EN` defined:
  - A watchdog counter runs in WAIT.
  - Reaching `TIMEOUT_CYC` with `eng_done`=0: `res_l`=`res_u`=0, `res_err`=1, `ack[owner]` pulses via ACK.
  - The engine is reset in ACK.
- `LU_ARB_TIMEOUT_EN` undefined:
  - No counter; WAIT lasts until `eng_done`.
  - `res_err` is tied to 0.

## Test plan
- Single job, identity: `req`=01 with A=I → `eng_start` 2 cycles after grant; `ack`=01 for one cycle; `res_l`=`res_u`=I; `res_err`=0; `busy` low after ack.
- Numeric job: `req`=10, A rows [2,1,0,0],[4,3,0,0],[0,0,1,0],[0,0,0,1] → `ack`=10; L[1][0]=2, rest of L = I; U[0][0]=2, U[0][1]=1, U[1][1]=1, U[2][2]=U[3][3]=1, rest of U = 0.
- Contention: `req`=11 held from reset release → order: owner 0, owner 1, owner 0. Each ack goes to the matching bit; each grant is preceded by an `eng_rst` pulse.
- Input stability: change `a0_in` during WAIT → result matches the matrix latched at grant.
- Timeout, with macro defined and `TIMEOUT_CYC`=15: stub engine holds `eng_done`=0 → ack 15–16 cycles after `eng_start`, with `res_err`=1 and `res_l`=`res_u`=0. Next `req` is served normally.
- Reset mid-WAIT: drop `rst_n` → `busy`=0, `ack`=0 and `eng_rst`=1 with no clock edge required. After release, `req`=01 completes normally.
